stack_control: RTL and testbench
================================

STACK_CONTROL -- requirements
Module: stack_control

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  run request; sampled in IDLE and HALT only.
REQ-004 new_instr  input  5  opcode field of current mem_data.
REQ-005 new_addr  input  11  address field of current mem_data.
REQ-006 tos_or  input  1  data-stack TOS non-zero flag.
REQ-007 r_tos  input  16  return-stack TOS.
REQ-008 mem_addr  output  11  memory address.
REQ-009 r_in  output  16  return-address value, zero-extended PC.
REQ-010 data_pop, data_push, dw_tos, dw_next, r_pop, r_push, rw_tos, w_mem, r_select  output  1 each  datapath strobes.
REQ-011 d_select  output  2  data-TOS source: 00 mem, 01 r_tos, 10 ALU, 11 r_tos-1.
REQ-012 alu_select  output  4  ALU operation.
REQ-013 busy  output  1  high in FETCH or EXEC.
REQ-014 halted  output  1  high in HALT.
REQ-015 illegal  output  1  sticky undefined-opcode flag; see REQ-036.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, EXEC, HALT; each instruction SHALL take exactly 2 cycles (FETCH then EXEC).
REQ-017 IDLE with start=1 SHALL go to FETCH; otherwise stay.
REQ-018 FETCH SHALL drive mem_addr=PC, latch IR<=new_instr and AR<=new_addr, set PC<=PC+1 (11-bit wrap 2047->0), then go to EXEC.
REQ-019 EXEC SHALL assert the strobes for IR for exactly one cycle, update PC if required, then go to FETCH (HALT for opcode HALT).
REQ-020 All strobes SHALL be 0 outside EXEC; mem_addr SHALL be PC outside EXEC and AR in EXEC.
REQ-021 00000 NOP: no strobes.
REQ-022 00001 HALT: no strobes; next state HALT.
REQ-023 00010 LOAD: data_push, dw_tos, d_select=00.
REQ-024 00011 STORE: w_mem, data_pop.
REQ-025 00100 JMP: PC<=AR.
REQ-026 00101 JZ: data_pop; PC<=AR when tos_or=0, else PC unchanged.
REQ-027 00110 CALL: r_push, rw_tos, r_select=0, r_in=PC (already incremented); PC<=AR.
REQ-028 00111 RET: r_pop; PC<=r_tos[10:0].
REQ-029 01000 TOR: r_push, rw_tos, r_select=1, data_pop.
REQ-030 01001 FROMR: data_push, dw_tos, d_select=01, r_pop.
REQ-031 01010 DECR: data_push, dw_tos, d_select=11.
REQ-032 1xxxx ALU: alu_select=IR[3:0], data_pop, dw_tos, dw_next, d_select=10.
REQ-033 01011-01111 are undefined; handled per REQ-036.
REQ-034 start SHALL be ignored in FETCH/EXEC; start in HALT SHALL set PC<=0 and go to FETCH next cycle.

Reset
REQ-035 rst=0 SHALL immediately force state IDLE, PC=0, IR=0, AR=0, illegal=0, and all outputs to 0 (mem_addr=0, busy=0, halted=0), including mid-instruction; operation resumes only through start.

Configuration
REQ-036 Macro STACK_CTRL_TRAP_EN: when defined, an undefined opcode in EXEC SHALL set illegal=1, assert no strobes, and go to HALT; illegal clears only on reset or on start from HALT. When undefined, undefined opcodes SHALL execute as NOP and illegal SHALL be tied to 0.

Verification
REQ-037 Reset, start; mem[0]=LOAD 0x010, mem[0x010]=0x1234 -> cycle 2 data_push=dw_tos=1, d_select=00, mem_addr=0x010; PC=1.
REQ-038 CALL 0x100 at PC=5 -> EXEC r_push=1, r_in=0x0006, next FETCH mem_addr=0x100; RET there -> FETCH mem_addr=0x006.
REQ-039 JZ 0x020 with tos_or=0 -> data_pop=1, next fetch 0x020; with tos_or=1 -> next fetch PC+1.
REQ-040 ALU opcode 10101 -> alu_select=0101, d_select=10, data_pop=dw_tos=dw_next=1 for one cycle.
REQ-041 Opcode 01100 with STACK_CTRL_TRAP_EN -> illegal=1, halted=1, no strobes; without the macro -> NOP, fetch continues; start in HALT -> fetch at 0.
REQ-042 rst=0 asserted during EXEC of STORE -> w_mem drops to 0 asynchronously, state IDLE, PC=0; JMP at PC=2047 target 0 and fall-through wrap to 0 both verified.

Source files
------------

// File: rtl/stack_control.sv
// Two-cycle FETCH/EXEC sequencer for a stack-machine datapath.
// Optional STACK_CTRL_TRAP_EN: trap undefined opcodes into HALT with illegal set.
module stack_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  new_instr,
    input  logic [10:0] new_addr,
    input  logic        tos_or,
    input  logic [15:0] r_tos,
    output logic [10:0] mem_addr,
    output logic [15:0] r_in,
    output logic        data_pop,
    output logic        data_push,
    output logic        dw_tos,
    output logic        dw_next,
    output logic        r_pop,
    output logic        r_push,
    output logic        rw_tos,
    output logic        w_mem,
    output logic        r_select,
    output logic [1:0]  d_select,
    output logic [3:0]  alu_select,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_HALT  = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_JMP   = 4'b0100;
    localparam logic [3:0] OP_JZ    = 4'b0101;
    localparam logic [3:0] OP_CALL  = 4'b0110;
    localparam logic [3:0] OP_RET   = 4'b0111;
    localparam logic [3:0] OP_TOR   = 4'b1000;
    localparam logic [3:0] OP_FROMR = 4'b1001;
    localparam logic [3:0] OP_DECR  = 4'b1010;

    state_t      state, state_next;
    logic [10:0] pc, pc_next;
    logic [4:0]  ir;
    logic [10:0] ar;

    // Only the low 11 bits of the return stack form a code address.
    logic unused_rtos;
    assign unused_rtos = ^r_tos[15:11];

    assign r_in   = {5'b0, pc};
    assign busy   = (state == FETCH) || (state == EXEC);
    assign halted = (state == HALT);

`ifdef STACK_CTRL_TRAP_EN
    logic illegal_q, illegal_set, illegal_clr;
    assign illegal = illegal_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            illegal_q <= 1'b0;
        else if (illegal_clr)
            illegal_q <= 1'b0;
        else if (illegal_set)
            illegal_q <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
            ar    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == FETCH) begin
                ir <= new_instr;
                ar <= new_addr;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        mem_addr   = pc;
        data_pop   = 1'b0;
        data_push  = 1'b0;
        dw_tos     = 1'b0;
        dw_next    = 1'b0;
        r_pop      = 1'b0;
        r_push     = 1'b0;
        rw_tos     = 1'b0;
        w_mem      = 1'b0;
        r_select   = 1'b0;
        d_select   = 2'b00;
        alu_select = 4'b0000;
`ifdef STACK_CTRL_TRAP_EN
        illegal_set = 1'b0;
        illegal_clr = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (start)
                    state_next = FETCH;
            end
            FETCH: begin
                pc_next    = pc + 11'd1;
                state_next = EXEC;
            end
            EXEC: begin
                mem_addr   = ar;
                state_next = FETCH;
                if (ir[4]) begin
                    alu_select = ir[3:0];
                    data_pop   = 1'b1;
                    dw_tos     = 1'b1;
                    dw_next    = 1'b1;
                    d_select   = 2'b10;
                end else begin
                    unique case (ir[3:0])
                        OP_NOP: ;
                        OP_HALT:
                            state_next = HALT;
                        OP_LOAD: begin
                            data_push = 1'b1;
                            dw_tos    = 1'b1;
                        end
                        OP_STORE: begin
                            w_mem    = 1'b1;
                            data_pop = 1'b1;
                        end
                        OP_JMP:
                            pc_next = ar;
                        OP_JZ: begin
                            data_pop = 1'b1;
                            if (!tos_or)
                                pc_next = ar;
                        end
                        OP_CALL: begin
                            r_push  = 1'b1;
                            rw_tos  = 1'b1;
                            pc_next = ar;
                        end
                        OP_RET: begin
                            r_pop   = 1'b1;
                            pc_next = r_tos[10:0];
                        end
                        OP_TOR: begin
                            r_push   = 1'b1;
                            rw_tos   = 1'b1;
                            r_select = 1'b1;
                            data_pop = 1'b1;
                        end
                        OP_FROMR: begin
                            data_push = 1'b1;
                            dw_tos    = 1'b1;
                            d_select  = 2'b01;
                            r_pop     = 1'b1;
                        end
                        OP_DECR: begin
                            data_push = 1'b1;
                            dw_tos    = 1'b1;
                            d_select  = 2'b11;
                        end
                        default: begin
`ifdef STACK_CTRL_TRAP_EN
                            illegal_set = 1'b1;
                            state_next  = HALT;
`endif
                        end
                    endcase
                end
            end
            HALT: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = FETCH;
`ifdef STACK_CTRL_TRAP_EN
                    illegal_clr = 1'b1;
`endif
                end
            end
            default:
                state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_control.sv
// Directed self-checking bench for stack_control with a 2K x 16 program memory
// model ({opcode[15:11], addr[10:0]}).
module tb_stack_control;

    logic        clk, rst, start, tos_or;
    logic [4:0]  new_instr;
    logic [10:0] new_addr;
    logic [15:0] r_tos;
    logic [10:0] mem_addr;
    logic [15:0] r_in;
    logic        data_pop, data_push, dw_tos, dw_next;
    logic        r_pop, r_push, rw_tos, w_mem, r_select;
    logic [1:0]  d_select;
    logic [3:0]  alu_select;
    logic        busy, halted, illegal;

    logic [15:0] mem [0:2047];
    logic [8:0]  strb;
    int          passed = 0;
    int          total = 0;

    assign new_instr = mem[mem_addr][15:11];
    assign new_addr  = mem[mem_addr][10:0];
    assign strb = {data_pop, data_push, dw_tos, dw_next,
                   r_pop, r_push, rw_tos, w_mem, r_select};

    stack_control dut (
        .clk(clk), .rst(rst), .start(start),
        .new_instr(new_instr), .new_addr(new_addr),
        .tos_or(tos_or), .r_tos(r_tos),
        .mem_addr(mem_addr), .r_in(r_in),
        .data_pop(data_pop), .data_push(data_push),
        .dw_tos(dw_tos), .dw_next(dw_next),
        .r_pop(r_pop), .r_push(r_push), .rw_tos(rw_tos),
        .w_mem(w_mem), .r_select(r_select),
        .d_select(d_select), .alu_select(alu_select),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_mem;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset;
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Leaves the bench at the negedge of the first FETCH cycle.
    task automatic start_run;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        clear_mem();
        tos_or = 1'b0;
        r_tos = 16'h0;
        start = 1'b0;
        rst = 1'b0;
        #3;
        total++; if (mem_addr !== 11'h0) $display("FAIL reset_addr got %h want 000", mem_addr); else passed++;
        total++; if ({strb, d_select, alu_select} !== 15'h0) $display("FAIL reset_strobes got %h want 0", {strb, d_select, alu_select}); else passed++;
        total++; if ({busy, halted, illegal, r_in} !== 19'h0) $display("FAIL reset_status got %h want 0", {busy, halted, illegal, r_in}); else passed++;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL idle_hold got %b want 0", busy); else passed++;
    endtask

    task automatic test_load;
        clear_mem();
        mem[0] = {5'b00010, 11'h010};
        mem[11'h010] = 16'h1234;
        do_reset();
        start_run();
        total++; if ({busy, mem_addr} !== {1'b1, 11'h000}) $display("FAIL load_fetch got %h want 1000", {busy, mem_addr}); else passed++;
        total++; if (strb !== 9'h0) $display("FAIL load_fetch_strb got %h want 000", strb); else passed++;
        @(negedge clk);
        total++; if ({strb, d_select} !== {9'b011000000, 2'b00}) $display("FAIL load_exec got %h want %h", {strb, d_select}, {9'b011000000, 2'b00}); else passed++;
        total++; if (mem_addr !== 11'h010) $display("FAIL load_ar got %h want 010", mem_addr); else passed++;
        @(negedge clk);
        total++; if ({strb, mem_addr} !== {9'h0, 11'h001}) $display("FAIL load_pc got %h want 001", {strb, mem_addr}); else passed++;
    endtask

    task automatic test_call_ret;
        clear_mem();
        mem[5] = {5'b00110, 11'h100};
        mem[11'h100] = {5'b00111, 11'h000};
        r_tos = 16'hF806;
        do_reset();
        start_run();
        start = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (mem_addr !== 11'h005) $display("FAIL call_fetch got %h want 005", mem_addr); else passed++;
        @(negedge clk);
        total++; if (strb !== 9'b000001100) $display("FAIL call_strb got %h want 00c", strb); else passed++;
        total++; if (r_in !== 16'h0006) $display("FAIL call_r_in got %h want 0006", r_in); else passed++;
        @(negedge clk);
        total++; if (mem_addr !== 11'h100) $display("FAIL call_target got %h want 100", mem_addr); else passed++;
        @(negedge clk);
        total++; if (strb !== 9'b000010000) $display("FAIL ret_strb got %h want 010", strb); else passed++;
        @(negedge clk);
        total++; if ({busy, mem_addr} !== {1'b1, 11'h006}) $display("FAIL ret_target got %h want 1006", {busy, mem_addr}); else passed++;
        start = 1'b0;
        r_tos = 16'h0;
    endtask

    task automatic test_jz;
        clear_mem();
        mem[0] = {5'b00101, 11'h020};
        mem[11'h020] = {5'b00101, 11'h040};
        do_reset();
        start_run();
        tos_or = 1'b0;
        @(negedge clk);
        total++; if (strb !== 9'b100000000) $display("FAIL jz_taken_strb got %h want 100", strb); else passed++;
        @(negedge clk);
        total++; if (mem_addr !== 11'h020) $display("FAIL jz_taken got %h want 020", mem_addr); else passed++;
        tos_or = 1'b1;
        @(negedge clk);
        total++; if (strb !== 9'b100000000) $display("FAIL jz_fall_strb got %h want 100", strb); else passed++;
        @(negedge clk);
        total++; if (mem_addr !== 11'h021) $display("FAIL jz_fall got %h want 021", mem_addr); else passed++;
        tos_or = 1'b0;
    endtask

    task automatic test_alu;
        clear_mem();
        mem[0] = {5'b10101, 11'h3AB};
        do_reset();
        start_run();
        @(negedge clk);
        total++; if ({strb, d_select, alu_select} !== {9'b101100000, 2'b10, 4'b0101}) $display("FAIL alu_exec got %h want %h", {strb, d_select, alu_select}, {9'b101100000, 2'b10, 4'b0101}); else passed++;
        @(negedge clk);
        total++; if ({strb, d_select, alu_select} !== 15'h0) $display("FAIL alu_one_cycle got %h want 0", {strb, d_select, alu_select}); else passed++;
    endtask

    task automatic test_misc_ops;
        clear_mem();
        mem[0] = {5'b01000, 11'h000};
        mem[1] = {5'b01001, 11'h000};
        mem[2] = {5'b01010, 11'h000};
        mem[3] = {5'b00011, 11'h055};
        mem[4] = {5'b00001, 11'h000};
        do_reset();
        start_run();
        @(negedge clk);
        total++; if (strb !== 9'b100001101) $display("FAIL tor got %h want 10d", strb); else passed++;
        repeat (2) @(negedge clk);
        total++; if ({strb, d_select} !== {9'b011010000, 2'b01}) $display("FAIL fromr got %h want %h", {strb, d_select}, {9'b011010000, 2'b01}); else passed++;
        repeat (2) @(negedge clk);
        total++; if ({strb, d_select} !== {9'b011000000, 2'b11}) $display("FAIL decr got %h want %h", {strb, d_select}, {9'b011000000, 2'b11}); else passed++;
        repeat (2) @(negedge clk);
        total++; if ({strb, mem_addr} !== {9'b100000010, 11'h055}) $display("FAIL store got %h want %h", {strb, mem_addr}, {9'b100000010, 11'h055}); else passed++;
        repeat (2) @(negedge clk);
        total++; if ({strb, busy} !== {9'h0, 1'b1}) $display("FAIL halt_exec got %h want 001", {strb, busy}); else passed++;
        repeat (2) @(negedge clk);
        total++; if ({busy, halted} !== 2'b01) $display("FAIL halt_state got %b want 01", {busy, halted}); else passed++;
        start_run();
        total++; if ({busy, halted, mem_addr} !== {2'b10, 11'h000}) $display("FAIL halt_restart got %h want 1000", {busy, halted, mem_addr}); else passed++;
    endtask

    task automatic test_illegal;
        clear_mem();
        mem[0] = {5'b01100, 11'h000};
        mem[1] = {5'b00010, 11'h000};
        do_reset();
        start_run();
        @(negedge clk);
        total++; if (strb !== 9'h0) $display("FAIL illegal_strb got %h want 000", strb); else passed++;
        @(negedge clk);
`ifdef STACK_CTRL_TRAP_EN
        total++; if ({illegal, halted, busy} !== 3'b110) $display("FAIL illegal_trap got %b want 110", {illegal, halted, busy}); else passed++;
        start_run();
        total++; if ({illegal, busy, mem_addr} !== {2'b01, 11'h000}) $display("FAIL illegal_clear got %h want 0800", {illegal, busy, mem_addr}); else passed++;
`else
        total++; if ({illegal, halted, busy, mem_addr} !== {3'b001, 11'h001}) $display("FAIL illegal_nop got %h want 0801", {illegal, halted, busy, mem_addr}); else passed++;
        @(negedge clk);
        total++; if (strb !== 9'b011000000) $display("FAIL illegal_next got %h want 0c0", strb); else passed++;
`endif
    endtask

    task automatic test_reset_mid;
        clear_mem();
        mem[0] = {5'b00011, 11'h077};
        mem[1] = {5'b00011, 11'h077};
        do_reset();
        start_run();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        total++; if (w_mem !== 1'b1) $display("FAIL mid_store got %b want 1", w_mem); else passed++;
        rst = 1'b0;
        #1;
        total++; if ({w_mem, data_pop, busy, mem_addr} !== 14'h0) $display("FAIL mid_reset got %h want 0", {w_mem, data_pop, busy, mem_addr}); else passed++;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({busy, mem_addr} !== 12'h0) $display("FAIL mid_idle got %h want 000", {busy, mem_addr}); else passed++;
    endtask

    task automatic test_wrap;
        clear_mem();
        mem[0] = {5'b00100, 11'h7FF};
        mem[11'h7FF] = {5'b00100, 11'h000};
        do_reset();
        start_run();
        repeat (2) @(negedge clk);
        total++; if (mem_addr !== 11'h7FF) $display("FAIL jmp_7ff got %h want 7ff", mem_addr); else passed++;
        repeat (2) @(negedge clk);
        total++; if ({busy, mem_addr} !== {1'b1, 11'h000}) $display("FAIL jmp_wrap got %h want 1000", {busy, mem_addr}); else passed++;
        mem[11'h7FF] = 16'h0000;
        do_reset();
        start_run();
        repeat (4) @(negedge clk);
        total++; if ({busy, mem_addr} !== {1'b1, 11'h000}) $display("FAIL pc_wrap got %h want 1000", {busy, mem_addr}); else passed++;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        tos_or = 1'b0;
        r_tos = 16'h0;
        test_reset();
        test_load();
        test_call_ret();
        test_jz();
        test_alu();
        test_misc_ops();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
